data_ram_ctrl: RTL and testbench

DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

---
 rtl/data_ram_ctrl.sv | 158 +++++++++++++++
 tb/tb_data_ram_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/data_ram_ctrl.sv
// Single-port data RAM controller: power-on/reset clear sweep, then direct or
// pointer-indirect single-word read/write accesses with configurable array latency.
module data_ram_ctrl #(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      ADDR_W   = 8,
  parameter int unsigned      LATENCY  = 1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic              indirect,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    PTR,
    ACCESS,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_ptr;
  logic [WIDTH-1:0]  r_wdata;
  logic [WIDTH-1:0]  r_rdata;
  logic              r_we;
  logic              r_ind;
  logic [CW-1:0]     r_lat;

  logic              w_lat_done;
  logic              w_accept;
  logic              w_lat_load;
  logic [ADDR_W-1:0] w_eff_addr;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [WIDTH-1:0]  w_mem_wdata;

  assign w_lat_done = (r_lat == '0);
  assign w_accept   = (r_state == IDLE) && req;
  assign w_lat_load = w_accept || ((r_state == PTR) && w_lat_done);
  assign w_eff_addr = r_ind ? r_ptr : r_addr;
  assign rdata      = r_rdata;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      CLEAR: begin
        if (r_clr_addr == '1) w_next = IDLE;
      end
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (req) w_next = indirect ? PTR : ACCESS;
      end
      PTR: begin
        if (w_lat_done) w_next = ACCESS;
      end
      ACCESS: begin
        if (w_lat_done) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = CLEAR;
    endcase
  end

  // Gating with clr keeps the array untouched while reset is held; an aborted
  // access never reaches its ACCESS exit, so its write is dropped too.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = w_eff_addr;
    w_mem_wdata = r_wdata;
    if (clr) begin
      if (r_state == CLEAR) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clr_addr;
        w_mem_wdata = INIT_VAL;
      end else if ((r_state == ACCESS) && w_lat_done && r_we) begin
        w_mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_clr_addr <= '0;
      r_addr     <= '0;
      r_ptr      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_we       <= 1'b0;
      r_ind      <= 1'b0;
      r_lat      <= '0;
    end else begin
      // Sweep counter saturates at DEPTH-1 so the last word is never revisited.
      if ((r_state == CLEAR) && (r_clr_addr != '1)) begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end

      if (w_accept) begin
        r_we    <= we;
        r_ind   <= indirect;
        r_addr  <= addr;
        r_wdata <= wdata;
      end

      if (w_lat_load) begin
        r_lat <= CW'(LATENCY - 1);
      end else if (((r_state == PTR) || (r_state == ACCESS)) && !w_lat_done) begin
        r_lat <= r_lat - 1'b1;
      end

      if ((r_state == PTR) && w_lat_done) begin
        r_ptr <= r_mem[r_addr][ADDR_W-1:0];
      end

      if ((r_state == ACCESS) && w_lat_done && !r_we) begin
        r_rdata <= r_mem[w_eff_addr];
      end
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl: two instances (LATENCY=1 and LATENCY=3)
// driven by the same stimulus, checked against hand-computed values.
module tb_data_ram_ctrl;

  logic        clk;
  logic        clr;
  logic        req;
  logic        we;
  logic        indirect;
  logic [7:0]  addr;
  logic [15:0] wdata;

  logic        ready1, busy1, done1;
  logic [15:0] rdata1;
  logic        ready3, busy3, done3;
  logic [15:0] rdata3;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [15:0] INIT = 16'hC3C3;

  data_ram_ctrl #(.WIDTH(16), .ADDR_W(8), .LATENCY(1), .INIT_VAL(INIT)) u_dut1 (
    .clk(clk), .clr(clr), .req(req), .we(we), .indirect(indirect),
    .addr(addr), .wdata(wdata),
    .ready(ready1), .busy(busy1), .done(done1), .rdata(rdata1)
  );

  data_ram_ctrl #(.WIDTH(16), .ADDR_W(8), .LATENCY(3), .INIT_VAL(INIT)) u_dut3 (
    .clk(clk), .clr(clr), .req(req), .we(we), .indirect(indirect),
    .addr(addr), .wdata(wdata),
    .ready(ready3), .busy(busy3), .done(done3), .rdata(rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Releases clr and measures the sweep length on both instances.
  task automatic sweep(input string tag);
    int r1 = 0;
    int r3 = 0;
    int nd = 0;
    @(negedge clk);
    clr = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (done1 || done3) nd++;
      if (ready1 && r1 == 0) r1 = i;
      if (ready3 && r3 == 0) r3 = i;
      if (r1 != 0 && r3 != 0) begin
        req = 1'b0;
        break;
      end
    end
    req = 1'b0;
    check({tag, "_ready_lat1"}, 32'(r1), 32'd256);
    check({tag, "_ready_lat3"}, 32'(r3), 32'd256);
    check({tag, "_no_done"}, 32'(nd), 32'd0);
  endtask

  // One request; latency counted in cycles with the accept cycle as cycle 1.
  task automatic access(input string tag, input logic w, input logic ind,
                        input logic [7:0] a, input logic [15:0] d,
                        input int e1, input int e3);
    int n1 = 0;
    int n3 = 0;
    @(negedge clk);
    for (int k = 0; k < 60 && !(ready1 && ready3); k++) @(negedge clk);
    check({tag, "_ready"}, 32'(ready1 & ready3), 32'd1);
    req = 1'b1; we = w; indirect = ind; addr = a; wdata = d;
    @(posedge clk);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req = 1'b0; we = 1'b0; indirect = 1'b0; addr = 8'h00; wdata = 16'h0000;
      end
      if (done1 && n1 == 0) n1 = i;
      if (done3 && n3 == 0) n3 = i;
      if (n1 != 0 && n3 != 0) break;
    end
    check({tag, "_lat1"}, 32'(n1), 32'(e1));
    check({tag, "_lat3"}, 32'(n3), 32'(e3));
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [15:0] exp);
    access(tag, 1'b0, 1'b0, a, 16'h0000, 2, 4);
    check({tag, "_rdata1"}, 32'(rdata1), 32'(exp));
    check({tag, "_rdata3"}, 32'(rdata3), 32'(exp));
  endtask

  initial begin
    int d1;
    int d3;
    clr = 1'b0; req = 1'b0; we = 1'b0; indirect = 1'b0; addr = 8'h00; wdata = 16'h0000;
    #2;
    check("rst_ready", 32'({ready1, ready3}), 32'd0);
    check("rst_busy",  32'({busy1, busy3}),   32'd3);
    check("rst_done",  32'({done1, done3}),   32'd0);
    check("rst_rdata", 32'({rdata1, rdata3}), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_ready", 32'({ready1, ready3}), 32'd0);

    // Request held high throughout the sweep must not be accepted.
    req = 1'b1;
    sweep("sweep0");

    rd_check("rd_00", 8'h00, INIT);
    rd_check("rd_ff", 8'hFF, INIT);

    access("wr_10", 1'b1, 1'b0, 8'h10, 16'h1234, 2, 4);
    check("wr_10_rdata_kept1", 32'(rdata1), 32'(INIT));
    check("wr_10_rdata_kept3", 32'(rdata3), 32'(INIT));
    rd_check("rd_10", 8'h10, 16'h1234);

    access("wr_05", 1'b1, 1'b0, 8'h05, 16'hAB20, 2, 4);
    access("wr_20", 1'b1, 1'b0, 8'h20, 16'h5A5A, 2, 4);
    access("ind_rd_05", 1'b0, 1'b1, 8'h05, 16'h0000, 3, 7);
    check("ind_rd_05_rdata1", 32'(rdata1), 32'h5A5A);
    check("ind_rd_05_rdata3", 32'(rdata3), 32'h5A5A);

    access("wr_01", 1'b1, 1'b0, 8'h01, 16'hFF07, 2, 4);
    access("ind_wr_01", 1'b1, 1'b1, 8'h01, 16'h0042, 3, 7);
    rd_check("rd_07", 8'h07, 16'h0042);
    rd_check("rd_01", 8'h01, 16'hFF07);

    access("wr_02", 1'b1, 1'b0, 8'h02, 16'h0002, 2, 4);
    access("self_rd_02", 1'b0, 1'b1, 8'h02, 16'h0000, 3, 7);
    check("self_rd_02_rdata1", 32'(rdata1), 32'h0002);
    access("self_wr_02", 1'b1, 1'b1, 8'h02, 16'hBEEF, 3, 7);
    rd_check("rd_02", 8'h02, 16'hBEEF);

    // req held for 9 edges: LATENCY=1 accepts every 3 edges, LATENCY=3 every 5.
    @(negedge clk);
    for (int k = 0; k < 60 && !(ready1 && ready3); k++) @(negedge clk);
    d1 = 0; d3 = 0;
    req = 1'b1; we = 1'b0; indirect = 1'b0; addr = 8'h10;
    for (int e = 0; e < 9; e++) begin
      @(negedge clk);
      if (done1) d1++;
      if (done3) d3++;
    end
    req = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      if (done1) d1++;
      if (done3) d3++;
    end
    check("held_done1", 32'(d1), 32'd3);
    check("held_done3", 32'(d3), 32'd2);
    check("held_rdata1", 32'(rdata1), 32'h1234);

    // Reset during the ACCESS phase of a write to 0x30.
    @(negedge clk);
    req = 1'b1; we = 1'b1; indirect = 1'b0; addr = 8'h30; wdata = 16'h9999;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    clr = 1'b0;
    #1;
    check("abort_ready", 32'({ready1, ready3}), 32'd0);
    check("abort_busy",  32'({busy1, busy3}),   32'd3);
    check("abort_done",  32'({done1, done3}),   32'd0);
    check("abort_rdata", 32'({rdata1, rdata3}), 32'd0);
    repeat (2) @(negedge clk);
    sweep("sweep1");
    rd_check("rd_30", 8'h30, INIT);
    rd_check("rd_10_cleared", 8'h10, INIT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
